// File: rtl/riscv_defines.sv
// Shared RISC-V core definitions: multiplier operator encodings, the shared
// dot-product unit default latency and the dot-product request bundle.
// Contents: mult_op_t, MUL_DOT8/MUL_DOT16, SHARED_DOTP_LATENCY, dotp_req_t, is_dotp_op().
package riscv_defines;

  localparam int MULT_OP_WIDTH = 3;
  typedef logic [MULT_OP_WIDTH-1:0] mult_op_t;

  localparam mult_op_t MUL_MAC32 = 3'b000;
  localparam mult_op_t MUL_MSU32 = 3'b001;
  localparam mult_op_t MUL_I     = 3'b010;
  localparam mult_op_t MUL_IR    = 3'b011;
  localparam mult_op_t MUL_DOT8  = 3'b100;
  localparam mult_op_t MUL_DOT16 = 3'b101;
  localparam mult_op_t MUL_H     = 3'b110;

  // Fixed pipeline depth of the cluster-shared dot-product multiplier.
  localparam int SHARED_DOTP_LATENCY = 2;

  // Operands forwarded from one core to the shared unit.
  typedef struct packed {
    mult_op_t    op;
    logic [1:0]  dot_signed;  // {a_signed, b_signed}
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } dotp_req_t;

  function automatic logic is_dotp_op(input mult_op_t op);
    return (op == MUL_DOT8) || (op == MUL_DOT16);
  endfunction

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Round-robin priority picker: the winner is the first set req bit at or
// above ptr, searching upward with wrap-around. Purely combinational.
// Ports: req_i (N), ptr_i (IDX_W) -> gnt_o (N, one-hot or zero), idx_o (IDX_W), vld_o (any grant).
module riscv_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  int   j;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      // ptr_i is always < N, so one subtraction is enough to wrap
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/riscv_shared_dotp_arbiter.sv
// Shares one fully pipelined DOT8/DOT16 unit among N_CORES cores: round-robin
// grant of one request per cycle, operand forwarding, and a LATENCY-deep
// requester-ID pipe that routes each result back as a one-cycle strobe.
// Ports: clk, rst_n (async active-low); core_req_i/core_gnt_o and per-core
// operator/signed/a/b/c (flattened, core i at slice i); core_r_valid_o,
// core_r_rdata_o (broadcast); dsp_req_o and dsp_* operands out; dsp_result_i in.
module riscv_shared_dotp_arbiter
  import riscv_defines::*;
#(
  parameter int N_CORES = 4,
  parameter int LATENCY = SHARED_DOTP_LATENCY,
  parameter int ID_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CORES-1:0]    core_req_i,
  output logic [N_CORES-1:0]    core_gnt_o,
  input  logic [N_CORES*3-1:0]  core_operator_i,
  input  logic [N_CORES*2-1:0]  core_dot_signed_i,
  input  logic [N_CORES*32-1:0] core_op_a_i,
  input  logic [N_CORES*32-1:0] core_op_b_i,
  input  logic [N_CORES*32-1:0] core_op_c_i,
  output logic [N_CORES-1:0]    core_r_valid_o,
  output logic [31:0]           core_r_rdata_o,
  output logic                  dsp_req_o,
  output logic [2:0]            dsp_operator_o,
  output logic [1:0]            dsp_signed_o,
  output logic [31:0]           dsp_op_a_o,
  output logic [31:0]           dsp_op_b_o,
  output logic [31:0]           dsp_op_c_o,
  input  logic [31:0]           dsp_result_i
);

  logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]              win_id;
  logic                         win_vld;
  dotp_req_t                    win_req;
  logic [LATENCY-1:0]           pipe_vld_q, pipe_vld_d;
  logic [LATENCY-1:0][ID_W-1:0] pipe_id_q, pipe_id_d;

  riscv_rr_arbiter #(
    .N     (N_CORES),
    .IDX_W (ID_W)
  ) u_rr (
    .req_i (core_req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (core_gnt_o),
    .idx_o (win_id),
    .vld_o (win_vld)
  );

  // AND-OR mux on the one-hot grant: all-zero grant leaves the dsp bus at
  // zero so the shared unit sees no toggling while idle.
  always_comb begin
    win_req = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (core_gnt_o[i]) begin
        win_req.op         = core_operator_i[i*3 +: 3];
        win_req.dot_signed = core_dot_signed_i[i*2 +: 2];
        win_req.a          = core_op_a_i[i*32 +: 32];
        win_req.b          = core_op_b_i[i*32 +: 32];
        win_req.c          = core_op_c_i[i*32 +: 32];
      end
    end
  end

  assign dsp_req_o      = win_vld;
  assign dsp_operator_o = win_req.op;
  assign dsp_signed_o   = win_req.dot_signed;
  assign dsp_op_a_o     = win_req.a;
  assign dsp_op_b_o     = win_req.b;
  assign dsp_op_c_o     = win_req.c;

  // Pointer moves just past the winner; it holds when nobody asks.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (win_vld) begin
      if (int'(win_id) == N_CORES - 1) rr_ptr_d = '0;
      else                             rr_ptr_d = win_id + ID_W'(1);
    end
  end

  // The unit never stalls, so the ID/valid pipe shifts unconditionally and
  // stage LATENCY-1 lines up with the cycle the result appears.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_id_d     = '0;
    pipe_vld_d[0] = win_vld;
    pipe_id_d[0]  = win_id;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_id_q  <= pipe_id_d;
    end
  end

  always_comb begin
    core_r_valid_o = '0;
    for (int i = 0; i < N_CORES; i++) begin
      core_r_valid_o[i] = pipe_vld_q[LATENCY-1] && (pipe_id_q[LATENCY-1] == ID_W'(i));
    end
  end

  // Result bus only carries data in a strobe cycle; zero otherwise.
  assign core_r_rdata_o = pipe_vld_q[LATENCY-1] ? dsp_result_i : 32'h0;

endmodule

// File: tb/tb_riscv_shared_dotp_arbiter.sv
module tb_riscv_shared_dotp_arbiter;
  import riscv_defines::*;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    core_req_i;
  logic [N-1:0]    core_gnt_o;
  logic [N*3-1:0]  core_operator_i;
  logic [N*2-1:0]  core_dot_signed_i;
  logic [N*32-1:0] core_op_a_i, core_op_b_i, core_op_c_i;
  logic [N-1:0]    core_r_valid_o;
  logic [31:0]     core_r_rdata_o;
  logic            dsp_req_o;
  logic [2:0]      dsp_operator_o;
  logic [1:0]      dsp_signed_o;
  logic [31:0]     dsp_op_a_o, dsp_op_b_o, dsp_op_c_o;
  logic [31:0]     dsp_result_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_shared_dotp_arbiter #(.N_CORES(N), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_operator_i(core_operator_i), .core_dot_signed_i(core_dot_signed_i),
    .core_op_a_i(core_op_a_i), .core_op_b_i(core_op_b_i), .core_op_c_i(core_op_c_i),
    .core_r_valid_o(core_r_valid_o), .core_r_rdata_o(core_r_rdata_o),
    .dsp_req_o(dsp_req_o), .dsp_operator_o(dsp_operator_o), .dsp_signed_o(dsp_signed_o),
    .dsp_op_a_o(dsp_op_a_o), .dsp_op_b_o(dsp_op_b_o), .dsp_op_c_o(dsp_op_c_o),
    .dsp_result_i(dsp_result_i)
  );

  // Dot product as defined by the ISA: signed/unsigned lanes, 32-bit wrap.
  function automatic logic [31:0] dotp(input logic [2:0] op, input logic [1:0] sg,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
    longint sum, ea, eb;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    sum = longint'({32'd0, c});
    if (op == MUL_DOT8) begin
      for (int k = 0; k < 4; k++) begin
        a8 = a[8*k +: 8];
        b8 = b[8*k +: 8];
        ea = sg[1] ? longint'($signed(a8)) : longint'({56'd0, a8});
        eb = sg[0] ? longint'($signed(b8)) : longint'({56'd0, b8});
        sum = sum + ea * eb;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        a16 = a[16*k +: 16];
        b16 = b[16*k +: 16];
        ea = sg[1] ? longint'($signed(a16)) : longint'({48'd0, a16});
        eb = sg[0] ? longint'($signed(b16)) : longint'({48'd0, b16});
        sum = sum + ea * eb;
      end
    end
    return sum[31:0];
  endfunction

  // Stand-in for the shared unit: LAT-stage pipeline fed from the dsp_* bus.
  logic [31:0] unit_pipe [LAT];
  always @(posedge clk) begin
    unit_pipe[0] <= dotp(dsp_operator_o, dsp_signed_o, dsp_op_a_o, dsp_op_b_o, dsp_op_c_o);
    for (int i = 1; i < LAT; i++) unit_pipe[i] <= unit_pipe[i-1];
  end
  assign dsp_result_i = unit_pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  int          m_ptr = 0;
  int          cyc   = 0;
  logic        s_vld [64];
  int          s_id  [64];
  logic [31:0] s_dat [64];

  initial begin
    for (int i = 0; i < 64; i++) s_vld[i] = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ptr = 0;
        for (int i = 0; i < 64; i++) s_vld[i] = 1'b0;
        chk("rst_r_valid", 32'(core_r_valid_o), 32'd0);
        chk("rst_r_rdata", core_r_rdata_o, 32'd0);
      end else begin
        int w, slot;
        logic [N-1:0] eg;
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && core_req_i[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        eg = (w >= 0) ? N'(1) << w : '0;
        chk("m_gnt", 32'(core_gnt_o), 32'(eg));
        chk("m_dsp_req", 32'(dsp_req_o), 32'(w >= 0));
        if (w >= 0) begin
          chk("m_dsp_op", 32'(dsp_operator_o), 32'(core_operator_i[w*3 +: 3]));
          chk("m_dsp_sg", 32'(dsp_signed_o), 32'(core_dot_signed_i[w*2 +: 2]));
          chk("m_dsp_a", dsp_op_a_o, core_op_a_i[w*32 +: 32]);
          chk("m_dsp_b", dsp_op_b_o, core_op_b_i[w*32 +: 32]);
          chk("m_dsp_c", dsp_op_c_o, core_op_c_i[w*32 +: 32]);
          assert (is_dotp_op(core_operator_i[w*3 +: 3]))
            else $error("illegal operator granted for core %0d", w);
        end else begin
          chk("m_dsp_idle", dsp_op_a_o | dsp_op_b_o | dsp_op_c_o |
              32'(dsp_operator_o) | 32'(dsp_signed_o), 32'd0);
        end
        slot = cyc % 64;
        chk("m_r_valid", 32'(core_r_valid_o), s_vld[slot] ? (32'd1 << s_id[slot]) : 32'd0);
        if (s_vld[slot]) chk("m_r_rdata", core_r_rdata_o, s_dat[slot]);
        s_vld[slot] = 1'b0;
        if (w >= 0) begin
          s_vld[(cyc + LAT) % 64] = 1'b1;
          s_id [(cyc + LAT) % 64] = w;
          s_dat[(cyc + LAT) % 64] = dotp(core_operator_i[w*3 +: 3], core_dot_signed_i[w*2 +: 2],
                                         core_op_a_i[w*32 +: 32], core_op_b_i[w*32 +: 32],
                                         core_op_c_i[w*32 +: 32]);
          m_ptr = (w + 1) % N;
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic [2:0] op, input logic [1:0] sg,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    core_operator_i[i*3 +: 3]    = op;
    core_dot_signed_i[i*2 +: 2]  = sg;
    core_op_a_i[i*32 +: 32]      = a;
    core_op_b_i[i*32 +: 32]      = b;
    core_op_c_i[i*32 +: 32]      = c;
  endtask

  initial begin
    logic [N-1:0] last_gnt;
    rst_n = 1'b0;
    core_req_i = '0;
    core_operator_i = '0; core_dot_signed_i = '0;
    core_op_a_i = '0; core_op_b_i = '0; core_op_c_i = '0;
    repeat (3) drive_edge();
    @(negedge clk);
    chk("reset_valid", 32'(core_r_valid_o), 32'd0);
    drive_edge();
    rst_n = 1'b1;

    // single DOT8 from core 2
    drive_edge();
    set_core(2, MUL_DOT8, 2'b00, 32'h01020304, 32'h01010101, 32'd0);
    core_req_i = 4'b0100;
    @(negedge clk); chk("single_gnt", 32'(core_gnt_o), 32'h4);
    drive_edge(); core_req_i = '0;
    @(negedge clk); chk("single_t1_valid", 32'(core_r_valid_o), 32'h0);
    drive_edge();
    @(negedge clk); chk("single_valid", 32'(core_r_valid_o), 32'h4);
    chk("single_rdata", core_r_rdata_o, 32'h0000000A);

    // sparse RR from pointer 3: core0 then core1, no gap
    drive_edge();
    set_core(0, MUL_DOT8, 2'b11, 32'h11223344, 32'h55667788, 32'h9);
    set_core(1, MUL_DOT16, 2'b01, 32'h00070008, 32'h8000FFFF, 32'h0);
    core_req_i = 4'b0011;
    @(negedge clk); chk("sparse_gnt0", 32'(core_gnt_o), 32'h1);
    drive_edge(); core_req_i = 4'b0010;
    @(negedge clk); chk("sparse_gnt1", 32'(core_gnt_o), 32'h2);
    drive_edge(); core_req_i = '0;

    // same core back-to-back DOT16 signed
    drive_edge();
    set_core(1, MUL_DOT16, 2'b11, 32'hFFFF0002, 32'h00030003, 32'd5);
    core_req_i = 4'b0010;
    @(negedge clk); chk("b2b_gnt_a", 32'(core_gnt_o), 32'h2);
    drive_edge();
    @(negedge clk); chk("b2b_gnt_b", 32'(core_gnt_o), 32'h2);
    drive_edge(); core_req_i = '0;
    @(negedge clk); chk("b2b_valid_a", 32'(core_r_valid_o), 32'h2);
    chk("b2b_rdata_a", core_r_rdata_o, 32'h00000008);
    drive_edge();
    @(negedge clk); chk("b2b_valid_b", 32'(core_r_valid_o), 32'h2);
    chk("b2b_rdata_b", core_r_rdata_o, 32'h00000008);

    // idle for 10 cycles, pointer must still be 2 afterwards
    for (int i = 0; i < 10; i++) begin
      drive_edge();
      @(negedge clk);
      chk("idle_req", 32'(dsp_req_o), 32'd0);
      chk("idle_bus", dsp_op_a_o | dsp_op_b_o | dsp_op_c_o, 32'd0);
      chk("idle_valid", 32'(core_r_valid_o), 32'd0);
    end
    drive_edge();
    set_core(3, MUL_DOT8, 2'b10, 32'h80FF7F01, 32'h02020202, 32'hFFFFFFFF);
    core_req_i = 4'b1111;
    @(negedge clk); chk("idle_ptr_kept", 32'(core_gnt_o), 32'h4);
    drive_edge(); core_req_i = '0;
    repeat (3) drive_edge();

    // reset while an op is in flight: no strobe, pointer back to 0
    core_req_i = 4'b0001;
    @(negedge clk); chk("rstmid_gnt", 32'(core_gnt_o), 32'h1);
    drive_edge(); core_req_i = '0; rst_n = 1'b0;
    @(negedge clk); chk("rstmid_valid0", 32'(core_r_valid_o), 32'h0);
    drive_edge();
    @(negedge clk); chk("rstmid_valid1", 32'(core_r_valid_o), 32'h0);
    drive_edge(); rst_n = 1'b1;
    @(negedge clk); chk("rstmid_valid2", 32'(core_r_valid_o), 32'h0);

    // all cores requesting continuously from pointer 0
    drive_edge();
    core_req_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_all_gnt", 32'(core_gnt_o), 32'd1 << (i % 4));
      if (i >= LAT) chk("rr_all_valid", 32'(core_r_valid_o), 32'd1 << ((i - LAT) % 4));
      drive_edge();
    end
    core_req_i = '0;
    repeat (3) drive_edge();

    // randomized traffic, with occasional resets
    last_gnt = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!core_req_i[i] || last_gnt[i]) begin
          if ($urandom_range(0, 99) < 55) begin
            set_core(i, ($urandom_range(0, 1) == 0) ? MUL_DOT8 : MUL_DOT16,
                     2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
            core_req_i[i] = 1'b1;
          end else begin
            core_req_i[i] = 1'b0;
          end
        end
      end
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      @(negedge clk);
      last_gnt = core_gnt_o;
      drive_edge();
    end
    core_req_i = '0;
    rst_n = 1'b1;
    repeat (4) drive_edge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
